// File: rtl/uart_pkg.sv
// ============================================================
// Package  : uart_pkg
// Brief    : Shared UART types, limits and baud helper.
// Revision : 1.0
// ============================================================
`default_nettype none

package uart_pkg;

  // Legal frame limits, shared with the receiver side.
  localparam int c_DATA_BITS_MIN = 5;
  localparam int c_DATA_BITS_MAX = 9;
  localparam int c_STOP_BITS_MIN = 1;
  localparam int c_STOP_BITS_MAX = 2;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } tx_state_t;
`endif

  function automatic int calc_ticks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
// ============================================================
// Interface : uart_tx_fifo_if
// Brief     : Valid/ready word handshake into the UART TX FIFO.
// Revision  : 1.0
// ============================================================
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo_buf.sv
// ============================================================
// Module   : uart_tx_fifo_buf
// Brief    : Synchronous FIFO with occupancy count and registered ready.
// Revision : 1.0
// ============================================================
`default_nettype none

module uart_tx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [PTR_W:0]   c_cnt_one  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   c_cnt_full = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_next;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;

  // ready is the only write gate, so a full FIFO can never take a word.
  assign w_push = wr_en && r_ready;
  assign w_pop  = rd_en && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      r_count <= w_count_next;
      r_ready <= (w_count_next != c_cnt_full);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign ready   = r_ready;
  assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================
// Module   : uart_tx_fifo
// Brief    : Parametrised UART transmitter fed by a small input FIFO.
//            Define UART_TX_PARITY_EN for a parity bit and parity_odd port.
// Revision : 1.0
// ============================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 in_if,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int TICKS_PER_BIT = calc_ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int BAUD_W        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int IDX_W         = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(TICKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] c_baud_one  = BAUD_W'(1);
  localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  c_idx_one   = IDX_W'(1);
  localparam logic              c_stop_last = 1'(STOP_BITS - 1);

  if (DATA_BITS < c_DATA_BITS_MIN || DATA_BITS > c_DATA_BITS_MAX ||
      STOP_BITS < c_STOP_BITS_MIN || STOP_BITS > c_STOP_BITS_MAX ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TICKS_PER_BIT < 1) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_t            r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_empty;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_bit_end;
  logic                 w_last_stop;
  logic                 w_pop;
  logic                 w_tx_level;

  uart_tx_fifo_buf #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_if.data_valid),
    .wr_data (in_if.data_in),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .empty   (w_empty),
    .ready   (in_if.data_ready),
    .count   (fifo_count)
  );

  assign w_bit_end   = (r_baud == c_baud_last);
  assign w_last_stop = (r_stop_idx == c_stop_last);
  // Pop from IDLE, or at the very end of the last stop bit for gapless frames.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) ||
                  (r_state == ST_STOP && w_bit_end && w_last_stop));

  always_comb begin
    w_tx_level = 1'b1;
    case (r_state)
      ST_START:  w_tx_level = 1'b0;
      ST_DATA:   w_tx_level = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_level = r_parity;
`endif
      default:   w_tx_level = 1'b1;
    endcase
  end

  // tx and busy trail the state by one cycle, so every bit stays TICKS_PER_BIT long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_tx   <= w_tx_level;
      r_busy <= (r_state != ST_IDLE);
      if (w_pop) begin
        r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
        r_parity <= (^w_head) ^ parity_odd;
`endif
      end
      if (r_state == ST_IDLE) begin
        r_baud <= '0;
        if (!w_empty) r_state <= ST_START;
      end else if (!w_bit_end) begin
        r_baud <= r_baud + c_baud_one;
      end else begin
        r_baud <= '0;
        case (r_state)
          ST_START: begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
          end
          ST_DATA: begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == c_idx_last) begin
              r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
              r_state    <= ST_PARITY;
`else
              r_state    <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + c_idx_one;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            r_state    <= ST_STOP;
            r_stop_idx <= 1'b0;
          end
`endif
          ST_STOP: begin
            if (!w_last_stop) begin
              r_stop_idx <= 1'b1;
            end else if (!w_empty) begin
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo (8N1 and 7N2 instances).
// Revision : 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo;
  localparam int T = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LA = 1 + 8 + P + 1;
  localparam int LB = 1 + 7 + P + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if_b ();
  logic       tx_a, busy_a, tx_b, busy_b;
  logic [2:0] cnt_a, cnt_b;
`ifdef UART_TX_PARITY_EN
  logic       parity_odd;
`endif

  uart_tx_fifo #(.CLOCK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .in_if(if_a),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

  uart_tx_fifo #(.CLOCK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_if(if_b),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));

  // Expected line levels, bit 0 = start bit; unused upper bits stay at idle/stop level.
  function automatic logic [15:0] mk_frame(input logic [8:0] w, input int db, input logic podd);
    logic [15:0] f;
    logic        par;
    f    = '1;
    f[0] = 1'b0;
    par  = podd;
    for (int i = 0; i < db; i++) begin
      f[1+i] = w[i];
      par    = par ^ w[i];
    end
    if (P == 1) f[1+db] = par;
    return f;
  endfunction

  // Receiver model for instance A: {stop_ok, parity, data}.
  int rx_q[$];
  initial begin : rx_model
    logic [7:0] d;
    logic       pb;
    logic       stop_ok;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_a === 1'b0) begin
        repeat (T + T/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          d[i] = tx_a;
          if (i < 7) repeat (T) @(negedge clk);
        end
        pb = 1'b0;
        if (P == 1) begin
          repeat (T) @(negedge clk);
          pb = tx_a;
        end
        repeat (T) @(negedge clk);
        stop_ok = tx_a;
        rx_q.push_back(int'({stop_ok, pb, d}));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge, data_valid still high.
  task automatic push_a(input logic [7:0] w, output bit to, output int waited);
    int g;
    g = 0;
    to = 1'b0;
    if_a.data_in    = w;
    if_a.data_valid = 1'b1;
    while (if_a.data_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) to = 1'b1;
    waited = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle_a(output bit to);
    int g;
    g = 0;
    while ((busy_a !== 1'b0 || cnt_a !== 3'd0 || tx_a !== 1'b1) && g < 600) begin
      @(negedge clk);
      g++;
    end
    to = (g >= 600);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (if_a.data_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: got %b want 0", if_a.data_ready); end
    n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    n_cmp++; if (tx_b !== 1'b1 || cnt_b !== 3'd0) begin n_err++; $display("FAIL reset_b: got tx=%b cnt=%0d want tx=1 cnt=0", tx_b, cnt_b); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (if_a.data_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b want 1", if_a.data_ready); end
    n_cmp++; if (if_b.data_ready !== 1'b1) begin n_err++; $display("FAIL ready_b_after_reset: got %b want 1", if_b.data_ready); end
    n_cmp++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: got tx=%b busy=%b want 1/0", tx_a, busy_a); end
  endtask

  task automatic test_single_frame();
    bit          to;
    int          wt;
    logic [15:0] f;
    rx_q.delete();
    push_a(8'hA5, to, wt);
    if_a.data_valid = 1'b0;
    n_cmp++; if (to) begin n_err++; $display("FAIL single_push_timeout: got timeout want accept"); end
    n_cmp++; if (cnt_a !== 3'd1 || tx_a !== 1'b1) begin n_err++; $display("FAIL single_after_accept: got cnt=%0d tx=%b want 1/1", cnt_a, tx_a); end
    @(negedge clk);
    n_cmp++; if (cnt_a !== 3'd0 || tx_a !== 1'b1 || busy_a !== 1'b0) begin n_err++; $display("FAIL single_after_pop: got cnt=%0d tx=%b busy=%b want 0/1/0", cnt_a, tx_a, busy_a); end
    f = mk_frame(9'h0A5, 8, 1'b0);
    for (int b = 0; b < LA; b++) begin
      for (int c = 0; c < T; c++) begin
        @(negedge clk);
        n_cmp++; if (tx_a !== f[b]) begin n_err++; $display("FAIL single_tx bit%0d cyc%0d: got %b want %b", b, c, tx_a, f[b]); end
        if (c == 0 && (b == 0 || b == LA - 1)) begin
          n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL single_busy bit%0d: got %b want 1", b, busy_a); end
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin n_err++; $display("FAIL single_end: got tx=%b busy=%b want 1/0", tx_a, busy_a); end
    n_cmp++; if (rx_q.size() != 1 || rx_q[0][7:0] != 8'hA5) begin n_err++; $display("FAIL single_rx: got n=%0d word=%h want n=1 word=a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0][7:0] : 8'h00); end
  endtask

  task automatic test_back_to_back();
    bit          to, to_any;
    int          wt, busy_hi, peak;
    logic [15:0] fr [3];
    to_any = 1'b0;
    fr[0] = mk_frame(9'h000, 8, 1'b0);
    fr[1] = mk_frame(9'h0FF, 8, 1'b0);
    fr[2] = mk_frame(9'h03C, 8, 1'b0);
    push_a(8'h00, to, wt); to_any |= to;
    push_a(8'hFF, to, wt); to_any |= to;
    push_a(8'h3C, to, wt); to_any |= to;
    if_a.data_valid = 1'b0;
    n_cmp++; if (to_any) begin n_err++; $display("FAIL b2b_push_timeout: got timeout want accept"); end
    busy_hi = 0;
    peak    = 0;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < LA; b++) begin
        for (int c = 0; c < T; c++) begin
          n_cmp++; if (tx_a !== fr[k][b]) begin n_err++; $display("FAIL b2b_tx f%0d bit%0d cyc%0d: got %b want %b", k, b, c, tx_a, fr[k][b]); end
          if (busy_a === 1'b1) busy_hi++;
          if (int'(cnt_a) > peak) peak = int'(cnt_a);
          @(negedge clk);
        end
      end
    end
    n_cmp++; if (busy_hi != 3 * LA * T) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want %0d", busy_hi, 3 * LA * T); end
    n_cmp++; if (peak < 2 || peak > 3) begin n_err++; $display("FAIL b2b_peak_count: got %0d want 2..3", peak); end
    n_cmp++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin n_err++; $display("FAIL b2b_end: got busy=%b tx=%b want 0/1", busy_a, tx_a); end
  endtask

  task automatic test_backpressure();
    bit         to, to_any;
    int         wt, g;
    logic [7:0] words [5];
    logic [7:0] exp_w [6];
    words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    exp_w = '{8'h11, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    to_any = 1'b0;
    rx_q.delete();
    push_a(8'h11, to, wt); to_any |= to;
    if_a.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL bp_line_busy: got %b want 1", busy_a); end
    for (int k = 0; k < 4; k++) begin
      push_a(words[k], to, wt); to_any |= to;
    end
    n_cmp++; if (cnt_a !== 3'd4 || if_a.data_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got cnt=%0d ready=%b want 4/0", cnt_a, if_a.data_ready); end
    push_a(words[4], to, wt); to_any |= to;
    if_a.data_valid = 1'b0;
    n_cmp++; if (to_any) begin n_err++; $display("FAIL bp_push_timeout: got timeout want accept"); end
    n_cmp++; if (wt < 1) begin n_err++; $display("FAIL bp_fifth_held: got wait=%0d want >0", wt); end
    n_cmp++; if (cnt_a !== 3'd4) begin n_err++; $display("FAIL bp_refill: got cnt=%0d want 4", cnt_a); end
    g = 0;
    while (rx_q.size() < 6 && g < 600) begin
      @(negedge clk);
      g++;
    end
    n_cmp++; if (rx_q.size() != 6) begin n_err++; $display("FAIL bp_frames: got %0d want 6", rx_q.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < rx_q.size()) begin
        n_cmp++; if (rx_q[k][7:0] != exp_w[k] || rx_q[k][9] != 1'b1) begin n_err++; $display("FAIL bp_word%0d: got %h stop=%b want %h stop=1", k, rx_q[k][7:0], rx_q[k][9], exp_w[k]); end
      end
    end
    wait_idle_a(to);
    n_cmp++; if (to) begin n_err++; $display("FAIL bp_idle_timeout: got busy=%b cnt=%0d want idle", busy_a, cnt_a); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit to;
    int wt;
    rx_q.delete();
    parity_odd = 1'b0;
    push_a(8'h07, to, wt);
    if_a.data_valid = 1'b0;
    wait_idle_a(to);
    parity_odd = 1'b1;
    push_a(8'h07, to, wt);
    if_a.data_valid = 1'b0;
    wait_idle_a(to);
    parity_odd = 1'b0;
    n_cmp++; if (rx_q.size() != 2) begin n_err++; $display("FAIL parity_frames: got %0d want 2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      n_cmp++; if (rx_q[0][8] != 1'b1 || rx_q[0][7:0] != 8'h07) begin n_err++; $display("FAIL parity_even: got par=%b word=%h want 1/07", rx_q[0][8], rx_q[0][7:0]); end
      n_cmp++; if (rx_q[1][8] != 1'b0 || rx_q[1][7:0] != 8'h07) begin n_err++; $display("FAIL parity_odd: got par=%b word=%h want 0/07", rx_q[1][8], rx_q[1][7:0]); end
    end
  endtask
`endif

  task automatic test_frame_7n2();
    logic [15:0] f;
    int          busy_hi;
    f = mk_frame(9'h041, 7, 1'b0);
    if_b.data_in    = 7'h41;
    if_b.data_valid = 1'b1;
    n_cmp++; if (if_b.data_ready !== 1'b1) begin n_err++; $display("FAIL b_ready: got %b want 1", if_b.data_ready); end
    @(posedge clk);
    @(negedge clk);
    if_b.data_valid = 1'b0;
    @(negedge clk);
    busy_hi = 0;
    for (int b = 0; b < LB; b++) begin
      for (int c = 0; c < T; c++) begin
        @(negedge clk);
        n_cmp++; if (tx_b !== f[b]) begin n_err++; $display("FAIL b_tx bit%0d cyc%0d: got %b want %b", b, c, tx_b, f[b]); end
        if (busy_b === 1'b1) busy_hi++;
      end
    end
    @(negedge clk);
    n_cmp++; if (busy_hi != LB * T) begin n_err++; $display("FAIL b_busy_cycles: got %0d want %0d", busy_hi, LB * T); end
    n_cmp++; if (tx_b !== 1'b1 || busy_b !== 1'b0) begin n_err++; $display("FAIL b_end: got tx=%b busy=%b want 1/0", tx_b, busy_b); end
  endtask

  task automatic test_reset_mid_frame();
    bit to, to_any;
    int wt, low_seen, busy_seen;
    to_any = 1'b0;
    push_a(8'h55, to, wt); to_any |= to;
    push_a(8'h33, to, wt); to_any |= to;
    push_a(8'h0F, to, wt); to_any |= to;
    if_a.data_valid = 1'b0;
    n_cmp++; if (to_any) begin n_err++; $display("FAIL rst_push_timeout: got timeout want accept"); end
    repeat (17) @(negedge clk);
    n_cmp++; if (cnt_a !== 3'd2 || tx_a !== 1'b0) begin n_err++; $display("FAIL rst_pre: got cnt=%0d tx=%b want 2/0", cnt_a, tx_a); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL rst_tx_immediate: got %b want 1", tx_a); end
    n_cmp++; if (cnt_a !== 3'd0 || busy_a !== 1'b0) begin n_err++; $display("FAIL rst_flush: got cnt=%0d busy=%b want 0/0", cnt_a, busy_a); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    low_seen  = 0;
    busy_seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) low_seen++;
      if (busy_a !== 1'b0) busy_seen++;
    end
    n_cmp++; if (low_seen != 0) begin n_err++; $display("FAIL rst_no_frames: got %0d low cycles want 0", low_seen); end
    n_cmp++; if (busy_seen != 0 || cnt_a !== 3'd0) begin n_err++; $display("FAIL rst_stays_idle: got busy_cycles=%0d cnt=%0d want 0/0", busy_seen, cnt_a); end
  endtask

  initial begin
    rst             = 1'b1;
    if_a.data_in    = '0;
    if_a.data_valid = 1'b0;
    if_b.data_in    = '0;
    if_b.data_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_odd      = 1'b0;
`endif
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_frame_7n2();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test want finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a small input FIFO and valid/ready handshake, generalising the fixed 8N1 transmitter to configurable data width, stop bits and optional parity. It sits between any word-producing logic, such as the fault-injection result reporter, and the board's serial TX pin. It transmits only queued words. It never re-sends stale data, and every bit period has an exact length.

## Interface
- CLOCK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, serial bit rate
- DATA_BITS, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- FIFO_DEPTH, 4, input FIFO entries, power of two, at least 2
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  DATA_BITS  word to transmit, LSB sent first
- data_valid  input  1  producer offers data_in this cycle
- data_ready  output  1  FIFO not full; word accepted when data_valid && data_ready
- tx  output  1  serial line, idle high
- busy  output  1  a frame is on the line
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued
- parity_odd  input  1  only with UART_TX_PARITY_EN; 0 = even parity, 1 = odd parity

## Operation
- TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE, integer division. Every bit, start and stop included, lasts exactly TICKS_PER_BIT clk cycles.
- Frame layout: start bit 0, then DATA_BITS data bits LSB first, then the parity bit if compiled in, then STOP_BITS stop bits of 1.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE→START: FIFO non-empty. Pop the head word into the shift register and compute parity.
  - START→DATA: after one bit period.
  - DATA→PARITY (or →STOP without parity): after DATA_BITS bit periods, counted by a bit index.
  - PARITY→STOP: after one bit period.
  - STOP→START: the last stop period ends and the FIFO is non-empty. This gives back-to-back frames with no idle gap.
  - STOP→IDLE: the last stop period ends and the FIFO is empty.
- Baud counter runs 0..TICKS_PER_BIT-1 and clears on every state entry from IDLE.
- FIFO handshake:
  - data_ready is registered as not-full.
  - A push while full is impossible by construction, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle are both honoured, and fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Input words change only on accepted handshakes. data_in is ignored when data_valid is 0.
- Reset values: tx=1, busy=0, data_ready=0 during reset and 1 from the first clk edge after reset deasserts, fifo_count=0, FSM=IDLE.
- A reset asserted mid-frame forces tx high immediately and flushes the FIFO. The partial frame is discarded and not resumed.

## Timing
- Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. tx falls at edge N+2. tx is a registered output.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × TICKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- busy rises with tx at the start bit and falls on the edge the last stop bit ends, unless the next frame starts at that edge.
- fifo_count updates on the edge following the push or pop.

## Configuration
- UART_TX_PARITY_EN defined:
  - the parity_odd port and the PARITY state exist;
  - parity bit = XOR of the data bits, inverted when parity_odd=1;
  - parity_odd is sampled at pop time.
- UART_TX_PARITY_EN undefined: there is no parity_odd port and no PARITY state, and DATA goes directly to STOP.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - a function that computes TICKS_PER_BIT from CLOCK_FREQ and BAUD_RATE;
  - DATA_BITS and STOP_BITS range-check constants, which are shared with the future receiver.
- Sub-module uart_tx_fifo_buf is the synchronous FIFO with count. It is parametrised by width and depth and has the same asynchronous reset.
- The FSM, baud counter and shift register live in the top module.

## Test plan
- Use CLOCK_FREQ=400, BAUD_RATE=100 (TICKS_PER_BIT=4), DATA_BITS=8, STOP_BITS=1, no parity. Push 0xA5 → tx is low for 4 cycles, then carries 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. The start bit appears 2 cycles after the accept edge.
- Push 0x00, 0xFF, 0x3C in consecutive cycles → three back-to-back frames with no idle cycles between stop and start. fifo_count peaks at 2 or 3, and busy stays high for 120 cycles.
- Push 5 words with FIFO_DEPTH=4 while the line is busy → data_ready drops when fifo_count=4 and the fifth word is held until a pop. All 5 words are transmitted in order.
- With UART_TX_PARITY_EN, parity_odd=0, 0x07 → parity bit 1. With parity_odd=1, 0x07 → parity bit 0.
- Use DATA_BITS=7, STOP_BITS=2, word 0x41 → frame is 0,1,0,0,0,0,0,1,1,1, which is 10 bit periods.
- Assert rst during the data bit 3 of a frame with 2 words queued → tx=1 in the same cycle, then fifo_count=0 and busy=0. After reset, tx stays idle with no further frames.
